data_mem_sized: RTL and testbench

//  Parametrised successor to the single-cycle data memory, used as the MIPS data memory.

---
 rtl/data_mem_sized.sv | 238 +++++++++++++++++++++++
 tb/tb_data_mem_sized.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_sized.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_sized
//  Purpose  : Byte-addressed 32-bit data memory with lb/lbu/lh/lhu/lw/sb/sh/sw
//             access. It has a valid/ready request port and gives a response
//             a fixed LATENCY cycles after each accepted request. Misaligned,
//             illegal-size and out-of-range requests are rejected. After every
//             reset, a sweep rewrites every word with its initial value.
//  Ports    : clk, rst (sync, active-high)
//             req_valid/req_ready handshake; req_we, req_size, req_unsigned,
//             req_addr[ADDR_W], req_wdata[32] request fields
//             resp_valid pulse with resp_rdata[32] and resp_err
//             init_busy high while the initialisation sweep runs
//  Revision : 1.0  initial release
// ============================================================================
module data_mem_sized #(
  parameter int DEPTH     = 64,  // 32-bit words, power of two, >= 2
  parameter int ADDR_W    = 8,   // byte-address width, 4*DEPTH <= 2**ADDR_W
  parameter int LATENCY   = 1,   // accept-to-response cycles, >= 1
  parameter int INIT_MODE = 1    // 0: clear, 1: word i <= i mod 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              init_busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  logic [31:0] mem_q [DEPTH];

  state_t             state_q,      state_d;
  logic [IDX_W-1:0]   init_idx_q,   init_idx_d;
  logic [CNT_W-1:0]   cnt_q,        cnt_d;
  logic               req_ready_q,  req_ready_d;
  logic               resp_valid_q, resp_valid_d;
  logic [31:0]        resp_rdata_q, resp_rdata_d;
  logic               resp_err_q,   resp_err_d;
  logic               init_busy_q,  init_busy_d;
  logic [31:0]        pend_rdata_q, pend_rdata_d;
  logic               pend_err_q,   pend_err_d;

  logic               accept;
  logic               req_err;
  logic [ADDR_W:0]    word_num;
  logic [IDX_W-1:0]   word_idx;
  logic [31:0]        rd_word;
  logic [7:0]         rd_byte;
  logic [15:0]        rd_half;
  logic [31:0]        load_data;
  logic [31:0]        result;
  logic [31:0]        init_word;
  logic               mem_we;
  logic [IDX_W-1:0]   mem_idx;
  logic [3:0]         mem_mask;
  logic [31:0]        mem_wdata;

  assign accept   = (state_q == S_IDLE) && req_ready_q && req_valid;
  assign word_num = {1'b0, req_addr} >> 2;
  assign word_idx = req_addr[IDX_W+1:2];

  // Request decode: error classification and load-data extraction.
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if (word_num >= DEPTH_A) req_err = 1'b1;

    rd_word = mem_q[word_idx];
    rd_byte = 8'(rd_word >> {req_addr[1:0], 3'b000});
    rd_half = req_addr[1] ? rd_word[31:16] : rd_word[15:0];

    case (req_size)
      2'b00:   load_data = req_unsigned ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   load_data = req_unsigned ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_data = rd_word;
    endcase

    // Stores and rejected requests report zero data.
    result = (req_we || req_err) ? 32'b0 : load_data;
  end

  assign init_word = (INIT_MODE != 0) ? (32'(init_idx_q) & 32'h0000_001F) : 32'b0;

  // Single array write port shared by the init sweep and accepted stores.
  // Sub-word store data is replicated across lanes so the mask alone picks it.
  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = init_idx_q;
    mem_mask  = 4'hF;
    mem_wdata = init_word;
    if (state_q == S_INIT) begin
      mem_we = 1'b1;
    end else if (accept && req_we && !req_err) begin
      mem_we  = 1'b1;
      mem_idx = word_idx;
      case (req_size)
        2'b00: begin
          mem_mask  = 4'b0001 << req_addr[1:0];
          mem_wdata = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          mem_mask  = req_addr[1] ? 4'b1100 : 4'b0011;
          mem_wdata = {2{req_wdata[15:0]}};
        end
        default: begin
          mem_mask  = 4'b1111;
          mem_wdata = req_wdata;
        end
      endcase
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    init_idx_d   = init_idx_q;
    cnt_d        = cnt_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    init_busy_d  = init_busy_q;
    pend_rdata_d = pend_rdata_q;
    pend_err_d   = pend_err_q;

    case (state_q)
      S_INIT: begin
        init_idx_d = init_idx_q + 1'b1;
        if (init_idx_q == LAST_IDX) begin
          state_d     = S_IDLE;
          init_busy_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      S_IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            // Response lands in the very next cycle; the port stays open
            // so single-cycle back-to-back requests are possible.
            resp_valid_d = 1'b1;
            resp_rdata_d = result;
            resp_err_d   = req_err;
          end else begin
            // The read happens now; only its extended result is held.
            state_d      = S_WAIT;
            req_ready_d  = 1'b0;
            cnt_d        = CNT_W'(LATENCY - 1);
            pend_rdata_d = result;
            pend_err_d   = req_err;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d      = S_IDLE;
          req_ready_d  = 1'b1;
          resp_valid_d = 1'b1;
          resp_rdata_d = pend_rdata_q;
          resp_err_d   = pend_err_q;
        end
      end
      default: begin
        state_d     = S_INIT;
        init_idx_d  = '0;
        req_ready_d = 1'b0;
        init_busy_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_INIT;
      init_idx_q   <= '0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'b0;
      resp_err_q   <= 1'b0;
      init_busy_q  <= 1'b1;
      pend_rdata_q <= 32'b0;
      pend_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_idx_q   <= init_idx_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      init_busy_q  <= init_busy_d;
      pend_rdata_q <= pend_rdata_d;
      pend_err_q   <= pend_err_d;
    end
  end

  // Array storage is not reset; the sweep after reset restores it. A store
  // coinciding with a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_mask[b]) mem_q[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign init_busy  = init_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_sized.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_data_mem_sized
//  Purpose  : Self-checking bench for data_mem_sized (DEPTH=64, ADDR_W=9,
//             LATENCY=3, INIT_MODE=1). Directed requests push hand-computed
//             responses into a scoreboard queue; a monitor pops and compares
//             on every resp_valid.
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_mem_sized;

  localparam int DEPTH     = 64;
  localparam int ADDR_W    = 9;
  localparam int LATENCY   = 3;
  localparam int INIT_MODE = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b10;
  logic              req_unsigned = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = 32'b0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              init_busy;

  data_mem_sized #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .LATENCY   (LATENCY),
    .INIT_MODE (INIT_MODE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .init_busy    (init_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          id;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   req_id   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  // The response cycle T+LATENCY begins LATENCY-1 edges after the accept edge.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got rdata=0x%08h err=%0b, expected no response",
                 resp_rdata, resp_err);
      end else begin
        mon_e = sb_q.pop_front();
        check($sformatf("rdata#%0d", mon_e.id), resp_rdata, mon_e.rdata);
        check($sformatf("err#%0d", mon_e.id), 32'(resp_err), 32'(mon_e.err));
        check($sformatf("latency#%0d", mon_e.id), 32'(cyc - mon_e.acc), 32'(LATENCY - 1));
      end
    end
  end

  // Drive one request, starting and ending on a negedge. acc is the index of
  // the posedge that accepts it.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input bit hold, input bit expect_resp, output int acc);
    int n;
    n = 0;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout#%0d: got req_ready=0 after %0d cycles, expected 1", req_id, n);
      req_valid = 1'b0;
      acc = -1;
      req_id++;
      return;
    end
    acc = cyc + 1;
    if (expect_resp) sb_q.push_back('{rdata: exp_rdata, err: exp_err, acc: acc, id: req_id});
    req_id++;
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic ld(input logic [1:0] size, input logic uns, input logic [ADDR_W-1:0] addr,
                    input logic [31:0] exp_rdata, input logic exp_err);
    int a;
    issue(1'b0, size, uns, addr, 32'h0, exp_rdata, exp_err, 1'b0, 1'b1, a);
  endtask

  task automatic st(input logic [1:0] size, input logic [ADDR_W-1:0] addr,
                    input logic [31:0] wdata, input logic exp_err);
    int a;
    issue(1'b1, size, 1'b0, addr, wdata, 32'h0, exp_err, 1'b0, 1'b1, a);
  endtask

  // Called on the negedge right after a reset edge: checks reset outputs,
  // releases rst, then measures the init sweep length.
  task automatic after_reset(input string tag);
    int n;
    int rdy_bad;
    check({tag, "_rst_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_rst_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_rst_busy"}, 32'(init_busy), 32'd1);
    check({tag, "_rst_rdata"}, resp_rdata, 32'h0);
    check({tag, "_rst_err"}, 32'(resp_err), 32'd0);
    rst = 1'b0;
    n = 0;
    rdy_bad = 0;
    while (init_busy && n < 200) begin
      if (req_ready) rdy_bad++;
      n++;
      @(negedge clk);
    end
    check({tag, "_init_cycles"}, 32'(n), 32'd64);
    check({tag, "_ready_in_init"}, 32'(rdy_bad), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by 200us, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, a3, n;

    // --- 1: reset, init sweep, first load; req_valid held during init is ignored
    rst          = 1'b1;
    req_valid    = 1'b1;
    req_we       = 1'b0;
    req_size     = 2'b10;
    req_addr     = 9'h014;
    @(negedge clk);
    after_reset("t1");
    ld(2'b10, 1'b0, 9'h014, 32'h0000_0005, 1'b0);
    ld(2'b10, 1'b0, 9'h0FC, 32'h0000_001F, 1'b0);   // last word, 63 mod 32
    ld(2'b10, 1'b0, 9'h000, 32'h0000_0000, 1'b0);

    // --- 2: sub-word loads with sign/zero extension
    st(2'b10, 9'h020, 32'h80FF_7F01, 1'b0);
    ld(2'b00, 1'b0, 9'h020, 32'h0000_0001, 1'b0);
    ld(2'b00, 1'b0, 9'h021, 32'h0000_007F, 1'b0);
    ld(2'b00, 1'b0, 9'h022, 32'hFFFF_FFFF, 1'b0);
    ld(2'b00, 1'b1, 9'h022, 32'h0000_00FF, 1'b0);
    ld(2'b01, 1'b0, 9'h022, 32'hFFFF_80FF, 1'b0);
    ld(2'b01, 1'b1, 9'h022, 32'h0000_80FF, 1'b0);
    ld(2'b00, 1'b0, 9'h023, 32'hFFFF_FF80, 1'b0);
    ld(2'b01, 1'b0, 9'h020, 32'h0000_7F01, 1'b0);
    ld(2'b10, 1'b1, 9'h020, 32'h80FF_7F01, 1'b0);

    // --- 3: byte/half stores touch only their lanes (upper wdata bits ignored)
    st(2'b00, 9'h031, 32'h5555_55AB, 1'b0);
    ld(2'b10, 1'b0, 9'h030, 32'h0000_AB0C, 1'b0);
    st(2'b01, 9'h032, 32'hFFFF_1234, 1'b0);
    ld(2'b10, 1'b0, 9'h030, 32'h1234_AB0C, 1'b0);

    // --- 4: rejected requests, memory untouched
    ld(2'b10, 1'b0, 9'h002, 32'h0, 1'b1);
    ld(2'b01, 1'b0, 9'h005, 32'h0, 1'b1);
    ld(2'b11, 1'b0, 9'h010, 32'h0, 1'b1);
    st(2'b10, 9'h100, 32'hDEAD_BEEF, 1'b1);
    st(2'b10, 9'h042, 32'hDEAD_BEEF, 1'b1);
    st(2'b11, 9'h044, 32'hDEAD_BEEF, 1'b1);
    ld(2'b00, 1'b0, 9'h1FF, 32'h0, 1'b1);
    ld(2'b10, 1'b0, 9'h040, 32'h0000_0010, 1'b0);
    ld(2'b10, 1'b0, 9'h044, 32'h0000_0011, 1'b0);
    ld(2'b10, 1'b0, 9'h000, 32'h0000_0000, 1'b0);
    ld(2'b01, 1'b0, 9'h006, 32'h0000_0000, 1'b0);

    // --- 5: req_valid held high across four loads
    issue(1'b0, 2'b10, 1'b0, 9'h008, 32'h0, 32'h0000_0002, 1'b0, 1'b1, 1'b1, a0);
    issue(1'b0, 2'b10, 1'b0, 9'h00C, 32'h0, 32'h0000_0003, 1'b0, 1'b1, 1'b1, a1);
    issue(1'b0, 2'b10, 1'b0, 9'h010, 32'h0, 32'h0000_0004, 1'b0, 1'b1, 1'b1, a2);
    issue(1'b0, 2'b10, 1'b0, 9'h018, 32'h0, 32'h0000_0006, 1'b0, 1'b0, 1'b1, a3);
    check("b2b_gap1", 32'(a1 - a0), 32'd3);
    check("b2b_gap2", 32'(a2 - a1), 32'd3);
    check("b2b_gap3", 32'(a3 - a2), 32'd3);

    // --- 6: reset while a store is waiting for its response
    issue(1'b1, 2'b10, 1'b0, 9'h028, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0, 1'b0, a0);
    rst = 1'b1;
    @(negedge clk);
    after_reset("t6");
    ld(2'b10, 1'b0, 9'h028, 32'h0000_000A, 1'b0);
    ld(2'b10, 1'b0, 9'h030, 32'h0000_000C, 1'b0);

    // Drain the scoreboard, then watch a few idle cycles for stray responses.
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_outstanding", 32'(sb_q.size()), 32'd0);
    repeat (6) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
